// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of one shared SPI pin set between flash (0) and RAM (1) controllers
module spi_bus_arbiter #(
   parameter int GAP_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   input  logic cs0_n,
   input  logic cs1_n,
   input  logic sck0,
   input  logic sck1,
   input  logic mosi0,
   input  logic mosi1,
   output logic miso0,
   output logic miso1,
   output logic spi_clk,
   output logic spi_mosi,
   input  logic spi_miso,
   output logic spi_cs0_n,
   output logic spi_cs1_n,
   output logic busy,
   output logic owner,
   output logic err
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
   state_t state;
   logic last;
   logic [3:0] gap_cnt;
   logic own0, own1;
   // ownership sequencing: grant on idle, release only when request and chip select are both inactive, then hold the bus quiet
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last    <= 1'b1;
         gap_cnt <= 4'd0;
         err     <= 1'b0;
      end else begin
         if ((!cs0_n && state != OWN0) || (!cs1_n && state != OWN1)) err <= 1'b1;
         case (state)
            IDLE: begin
               if (req0 && (!req1 || last)) state <= OWN0;
               else if (req1) state <= OWN1;
            end
            OWN0: begin
               if (!req0 && cs0_n) begin
                  last    <= 1'b0;
                  gap_cnt <= GAP_LOAD;
                  state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            end
            OWN1: begin
               if (!req1 && cs1_n) begin
                  last    <= 1'b1;
                  gap_cnt <= GAP_LOAD;
                  state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) state <= IDLE;
               else gap_cnt <= gap_cnt - 4'd1;
            end
         endcase
      end
   end
   assign own0      = (state == OWN0);
   assign own1      = (state == OWN1);
   assign gnt0      = own0;
   assign gnt1      = own1;
   assign busy      = (state != IDLE);
   assign owner     = own0 ? 1'b0 : own1 ? 1'b1 : last;
   assign spi_clk   = own0 ? sck0 : own1 ? sck1 : 1'b0;
   assign spi_mosi  = own0 ? mosi0 : own1 ? mosi1 : 1'b0;
   assign spi_cs0_n = own0 ? cs0_n : 1'b1;
   assign spi_cs1_n = own1 ? cs1_n : 1'b1;
   assign miso0     = own0 ? spi_miso : 1'b0;
   assign miso1     = own1 ? spi_miso : 1'b0;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: time-based reference model for gap=2 and gap=0 instances plus directed literal checks
module tb_spi_bus_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
   logic sck0 = 1'b0, sck1 = 1'b0, mosi0 = 1'b0, mosi1 = 1'b0, spi_miso = 1'b0;
   logic gnt0 [2], gnt1 [2], miso0 [2], miso1 [2], spi_clk [2], spi_mosi [2];
   logic spi_cs0_n [2], spi_cs1_n [2], busy [2], owner [2], err [2];
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int m_own [2] = '{-1, -1};
   int m_free [2] = '{0, 0};
   int m_last [2] = '{1, 1};
   bit m_err [2] = '{1'b0, 1'b0};
   int gapv [2] = '{2, 0};

   spi_bus_arbiter #(.GAP_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0[0]), .gnt1(gnt1[0]),
      .cs0_n(cs0_n), .cs1_n(cs1_n), .sck0(sck0), .sck1(sck1), .mosi0(mosi0), .mosi1(mosi1),
      .miso0(miso0[0]), .miso1(miso1[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]),
      .spi_miso(spi_miso), .spi_cs0_n(spi_cs0_n[0]), .spi_cs1_n(spi_cs1_n[0]),
      .busy(busy[0]), .owner(owner[0]), .err(err[0]));

   spi_bus_arbiter #(.GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0[1]), .gnt1(gnt1[1]),
      .cs0_n(cs0_n), .cs1_n(cs1_n), .sck0(sck0), .sck1(sck1), .mosi0(mosi0), .mosi1(mosi1),
      .miso0(miso0[1]), .miso1(miso1[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]),
      .spi_miso(spi_miso), .spi_cs0_n(spi_cs0_n[1]), .spi_cs1_n(spi_cs1_n[1]),
      .busy(busy[1]), .owner(owner[1]), .err(err[1]));

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1;
      sck0 = 1'b0; sck1 = 1'b0; mosi0 = 1'b0; mosi1 = 1'b0;
      tick;
      rst = 1'b0;
   endtask

   // reference model: owner plus the earliest cycle a new grant is allowed after a release
   always @(posedge clk) begin
      logic [1:0] rq, cs;
      rq = {req1, req0};
      cs = {cs1_n, cs0_n};
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_own[k] = -1; m_last[k] = 1; m_err[k] = 1'b0; m_free[k] = 0;
         end else begin
            if ((!cs0_n && m_own[k] != 0) || (!cs1_n && m_own[k] != 1)) m_err[k] = 1'b1;
            if (m_own[k] >= 0) begin
               if (!rq[m_own[k]] && cs[m_own[k]]) begin
                  m_last[k] = m_own[k];
                  m_own[k]  = -1;
                  m_free[k] = cyc + gapv[k] + 1;
               end
            end else if (cyc >= m_free[k]) begin
               if (rq == 2'b11) m_own[k] = 1 - m_last[k];
               else if (rq[0]) m_own[k] = 0;
               else if (rq[1]) m_own[k] = 1;
            end
         end
      end
   end

   // per-cycle comparison of every output of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            int o;
            logic [10:0] e, a;
            o = m_own[k];
            e = {o == 0, o == 1, (o >= 0) || (cyc + 1 < m_free[k]),
                 (o >= 0) ? (o == 1) : (m_last[k] == 1), m_err[k],
                 (o == 0) ? sck0 : (o == 1) ? sck1 : 1'b0,
                 (o == 0) ? mosi0 : (o == 1) ? mosi1 : 1'b0,
                 (o == 0) ? cs0_n : 1'b1, (o == 1) ? cs1_n : 1'b1,
                 (o == 0) ? spi_miso : 1'b0, (o == 1) ? spi_miso : 1'b0};
            a = {gnt0[k], gnt1[k], busy[k], owner[k], err[k], spi_clk[k], spi_mosi[k],
                 spi_cs0_n[k], spi_cs1_n[k], miso0[k], miso1[k]};
            chk($sformatf("cycle%0d_inst%0d{gnt0,gnt1,busy,owner,err,clk,mosi,cs0,cs1,miso0,miso1}", cyc, k), a, e);
         end
      end
   end

   initial begin
      logic [7:0] tx, rx;
      logic [3:0] order;
      int na, nb, w;
      bit r [2], c [2], s [2], mo [2];
      int ph [2], len [2];
      rst = 1'b1;
      tick;
      chk_en = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst_busy", busy[0], 0);
      chk("rst_owner", owner[0], 1);
      chk("rst_gnt", {gnt0[0], gnt1[0]}, 0);
      chk("rst_cs", {spi_cs0_n[0], spi_cs1_n[0]}, 2'b11);
      chk("rst_err", err[0], 0);
      // single flash read
      req0 = 1'b1;
      tick;
      chk("grant_lat", gnt0[0], 1);
      chk("grant_cs1_idle", spi_cs1_n[0], 1);
      cs0_n = 1'b0;
      tick;
      sck0 = 1'b1; mosi0 = 1'b1;
      #1;
      chk("pass_clk", spi_clk[0], 1);
      chk("pass_mosi", spi_mosi[0], 1);
      chk("pass_cs", spi_cs0_n[0], 0);
      sck0 = 1'b0; mosi0 = 1'b0;
      tx = 8'hA5; rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         spi_miso = tx[i];
         sck0 = 1'b0;
         tick;
         sck0 = 1'b1;
         #1;
         rx = {rx[6:0], miso0[0]};
         chk("miso1_zero", miso1[0], 0);
      end
      chk("miso_byte", rx, 8'hA5);
      sck0 = 1'b0; cs0_n = 1'b1; req0 = 1'b0; spi_miso = 1'b0;
      tick;
      chk("release_gnt", gnt0[0], 0);
      chk("gap_busy", busy[0], 1);
      repeat (3) tick;
      // simultaneous first requests, gap latency on both instances
      do_reset;
      req0 = 1'b1; req1 = 1'b1;
      tick;
      chk("tie_first", {gnt0[0], gnt1[0]}, 2'b10);
      cs0_n = 1'b0;
      repeat (3) tick;
      cs0_n = 1'b1; req0 = 1'b0;
      tick;
      na = 0; nb = 0;
      for (int n = 1; n <= 6; n++) begin
         tick;
         if (gnt1[0] && na == 0) na = n;
         if (gnt1[1] && nb == 0) nb = n;
      end
      chk("gap_lat", na, 3);
      chk("zero_gap_lat", nb, 1);
      // reset during an OWN1 transfer
      cs1_n = 1'b0; sck1 = 1'b1;
      tick;
      chk("own1_cs", spi_cs1_n[0], 0);
      rst = 1'b1;
      tick;
      chk("midrst_cs", spi_cs1_n[0], 1);
      chk("midrst_gnt", gnt1[0], 0);
      chk("midrst_busy", busy[0], 0);
      chk("midrst_b", {gnt1[1], spi_cs1_n[1], busy[1]}, 3'b010);
      rst = 1'b0; req1 = 1'b0; cs1_n = 1'b1; sck1 = 1'b0;
      tick;
      // round-robin alternation
      do_reset;
      req0 = 1'b1; req1 = 1'b1; order = 4'h0;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (!(gnt0[0] || gnt1[0]) && w < 10) begin
            tick;
            w++;
         end
         if (i > 0) chk("rr_gap", w, 3);
         order[i] = gnt1[0];
         if (!gnt1[0]) begin
            cs0_n = 1'b0; repeat (2) tick;
            cs0_n = 1'b1; req0 = 1'b0; tick; req0 = 1'b1;
         end else begin
            cs1_n = 1'b0; repeat (2) tick;
            cs1_n = 1'b1; req1 = 1'b0; tick; req1 = 1'b1;
         end
      end
      chk("rr_order", order, 4'b1010);
      // early request drop keeps ownership until chip select rises
      do_reset;
      req0 = 1'b1;
      tick;
      cs0_n = 1'b0;
      tick;
      req0 = 1'b0;
      repeat (3) tick;
      chk("hold_gnt", gnt0[0], 1);
      cs0_n = 1'b1;
      tick;
      chk("drop_release", {gnt0[0], busy[0], owner[0]}, 3'b010);
      // protocol violation by the non-owner
      do_reset;
      req0 = 1'b1;
      tick;
      cs0_n = 1'b0; cs1_n = 1'b0;
      #1;
      chk("viol_pin", spi_cs1_n[0], 1);
      tick;
      chk("viol_err", err[0], 1);
      cs1_n = 1'b1; cs0_n = 1'b1; req0 = 1'b0;
      repeat (4) tick;
      chk("err_sticky", err[0], 1);
      do_reset;
      chk("err_clear", err[0], 0);
      // randomized traffic from two well-behaved agents that start only once granted
      for (int x = 0; x < 2; x++) begin
         r[x] = 0; c[x] = 1; s[x] = 0; mo[x] = 0; ph[x] = 0; len[x] = 0;
      end
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            for (int x = 0; x < 2; x++) begin
               r[x] = 0; c[x] = 1; s[x] = 0; ph[x] = 0;
            end
         end else begin
            rst = 1'b0;
            for (int x = 0; x < 2; x++) begin
               case (ph[x])
                  0: begin
                     s[x] = 0;
                     if ($urandom_range(0, 3) == 0) begin r[x] = 1; ph[x] = 1; end
                  end
                  1: begin
                     if (m_own[0] == x) begin c[x] = 0; len[x] = $urandom_range(1, 6); ph[x] = 2; end
                  end
                  default: begin
                     s[x] = 1'($urandom_range(0, 1));
                     mo[x] = 1'($urandom_range(0, 1));
                     if ($urandom_range(0, 7) == 0) r[x] = 0;
                     len[x]--;
                     if (len[x] == 0) begin c[x] = 1; r[x] = 0; s[x] = 0; ph[x] = 0; end
                  end
               endcase
            end
         end
         spi_miso = 1'($urandom_range(0, 1));
         req0 = r[0]; req1 = r[1]; cs0_n = c[0]; cs1_n = c[1];
         sck0 = s[0]; sck1 = s[1]; mosi0 = mo[0]; mosi1 = mo[1];
         tick;
      end
      do_reset;
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
